// File: rtl/cacheline_burst_adapter.sv
// Cache-line to burst-DRAM adapter: one line request becomes a BEATS-beat read or write burst.
// Optional build macro ADAPTER_RADDR_CHECK_EN enables read-beat address tag checking and adapter_err.
module cacheline_burst_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              adapter_err
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_REQ   = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] aligned_addr;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rline_q;
  logic [LINE_W-1:0] rline_next;
  logic              raddr_match;
  logic              beat_take;
  logic              unused_low_addr;

  assign aligned_addr    = {dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_low_addr = ^dfp_addr[OFF_W-1:0];

`ifdef ADAPTER_RADDR_CHECK_EN
  assign raddr_match = (bmem_raddr == addr_q);
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign raddr_match  = 1'b1;
`endif

  assign beat_take = (state == RD_WAIT) && bmem_rvalid && raddr_match;

  // The final beat is merged combinationally so dfp_rdata can be loaded in the same edge.
  always_comb begin
    // NOTE: default first so every path assigns rline_next and no latch is inferred.
    rline_next = rline_q;
    rline_next[beat_cnt*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      addr_q    <= '0;
      dfp_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (dfp_write) begin
            addr_q <= aligned_addr;
            state  <= WR_BURST;
          end else if (dfp_read) begin
            addr_q <= aligned_addr;
            state  <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            beat_cnt <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (beat_take) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              dfp_rdata <= rline_next;
              state     <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: line buffers are datapath only; outputs are gated by state, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && dfp_write) wline_q <= dfp_wdata;
    if (beat_take)                  rline_q <= rline_next;
  end

`ifdef ADAPTER_RADDR_CHECK_EN
  logic bad_beat;
  logic bad_write;
  assign bad_beat  = (state == RD_WAIT) && bmem_rvalid && !raddr_match;
  assign bad_write = dfp_write && ((state == RD_REQ) || (state == RD_WAIT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      adapter_err <= 1'b0;
    end else begin
      if (bad_beat || bad_write) adapter_err <= 1'b1;
      if (bad_beat) $error("read beat tag %h does not match burst address %h", bmem_raddr, addr_q);
    end
  end
`else
  assign adapter_err = 1'b0;
`endif

  assign bmem_read  = (state == RD_REQ);
  assign bmem_write = (state == WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? wline_q[beat_cnt*BEAT_W +: BEAT_W] : '0;
  assign dfp_resp   = (state == DONE);

endmodule
